bk_serial_add_ctrl: RTL and testbench

//   Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit

---
 rtl/bk_serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_bk_serial_add_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_serial_add_ctrl.sv
// bk_serial_add_ctrl
// Sequences a WIDTH-bit add or subtract through one external 4-bit adder slice.
// It issues one nibble per cycle, least significant first. The carry between
// nibbles is held in a register. The full result is returned over a
// valid/ready handshake.
module bk_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_c0,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;

    // Operands are accepted only in IDLE. While reset is asserted, the block
    // does not advertise readiness.
    assign in_ready = rst_n && (state == IDLE);

    // Drive the adder slice from the latched operands during RUN only.
    // Outside RUN the adder inputs are held at zero.
    always_comb begin
        add_a  = 4'd0;
        add_b  = 4'd0;
        add_c0 = 1'b0;
        if (state == RUN) begin
            add_a  = a_r[4*int'(idx) +: 4];
            add_b  = b_r[4*int'(idx) +: 4];
            add_c0 = carry;
        end
    end

    // Main sequencer: latch operands, collect one adder nibble per edge, then
    // hold the result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b ^ {WIDTH{op_sub}};
                        carry <= op_sub ? 1'b1 : c_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[4*int'(idx) +: 4] <= add_s;
                    carry                 <= add_cout;
                    idx                   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        c_out     <= add_cout;
                        ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (add_s[3] != a_r[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bk_serial_add_ctrl.sv
// tb_bk_serial_add_ctrl
// Bench for the serial add/subtract sequencer with WIDTH=16. A behavioural
// 4-bit adder answers the ADD_* ports. Results are compared against a table of
// hand-computed vectors, against hand-written corner sequences, and against a
// plain-arithmetic reference model under random operands.
module tb_bk_serial_add_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             busy;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_c0;
    logic [3:0]       add_s;
    logic             add_cout;

    int checks = 0;
    int errors = 0;

    bk_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c0    (add_c0),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the external 4-bit adder slice.
    assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_c0);

    typedef struct {
        logic        sub;
        logic [15:0] av;
        logic [15:0] bv;
        logic        ci;
        logic [15:0] expSum;
        logic        expCout;
        logic        expOvf;
    } vec_t;

    vec_t vecs[8];

    logic [15:0] gotSum;
    logic        gotCout;
    logic        gotOvf;
    int          gotLat;
    logic        gotBusy;
    logic [3:0]  c0Trace;

    // Record one comparison and report it if it disagrees.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on whole operands.
    task automatic refModel(input logic sub, input logic [15:0] av, input logic [15:0] bv,
                            input logic ci, output logic [15:0] s, output logic co,
                            output logic ov);
        int sa;
        int sb;
        int r;
        logic [16:0] u;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (sub) begin
            s  = av - bv;
            co = (av >= bv);
            r  = sa - sb;
        end else begin
            u  = 17'(av) + 17'(bv) + 17'(ci);
            s  = u[15:0];
            co = u[16];
            r  = sa + sb + int'(ci);
        end
        ov = (r > 32767) || (r < -32768);
    endtask

    // Offer one operand pair, then wait for the result.
    // Records the result, the latency, and the carry-in seen on each pass.
    // Called and returns at 1 ns after a rising edge.
    task automatic applyStimulus(input logic sub, input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci);
        int waitCnt;
        waitCnt = 0;
        while (!in_ready && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("ready_before_op", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_sub   = sub;
        a        = av;
        b        = bv;
        c_in     = ci;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'(av + 16'h5A5A);
        b        = 16'(bv ^ 16'hA5A5);
        gotBusy  = busy;
        c0Trace  = 4'b0000;
        gotLat   = 1;
        while (!out_valid && gotLat <= 20) begin
            if (gotLat <= 4) c0Trace[gotLat-1] = add_c0;
            @(posedge clk); #1;
            gotLat++;
        end
        gotLat  = gotLat - 1;
        gotSum  = sum;
        gotCout = c_out;
        gotOvf  = ovf;
    endtask

    // Release the result and confirm the return to IDLE on the same edge.
    task automatic finishOp();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] hs;
        logic        hc;
        logic        ho;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic        rc;
        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h0003, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_add_a", 32'(add_a), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].sub, vecs[i].av, vecs[i].bv, vecs[i].ci);
            checkOutput($sformatf("vec%0d_sum", i), 32'(gotSum), 32'(vecs[i].expSum));
            checkOutput($sformatf("vec%0d_cout", i), 32'(gotCout), 32'(vecs[i].expCout));
            checkOutput($sformatf("vec%0d_ovf", i), 32'(gotOvf), 32'(vecs[i].expOvf));
            checkOutput($sformatf("vec%0d_latency", i), 32'(gotLat), 32'd4);
            checkOutput($sformatf("vec%0d_busy_run", i), 32'(gotBusy), 32'd1);
            if (i == 1) checkOutput("carry_chain_c0", 32'(c0Trace), 32'b1110);
            if (i == 2) checkOutput("sub_c0_trace0", 32'(c0Trace[0]), 32'd1);
            finishOp();
        end

        // Result held in DONE under back-pressure while new operands are offered.
        applyStimulus(1'b0, 16'h0F0F, 16'h1111, 1'b1);
        hs = sum;
        hc = c_out;
        ho = ovf;
        checkOutput("hold_initial_sum", 32'(hs), 32'h2021);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            a        = 16'($urandom);
            b        = 16'($urandom);
            @(posedge clk); #1;
            checkOutput($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
            checkOutput($sformatf("hold%0d_out_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("hold%0d_result", k), {14'd0, ho, hc, hs}, {14'd0, ovf, c_out, sum});
            checkOutput($sformatf("hold%0d_add_a", k), 32'(add_a), 32'd0);
        end
        in_valid = 1'b0;
        finishOp();
        checkOutput("hold_sum_after_release", 32'(sum), 32'h2021);

        // Reset asserted during the third RUN pass aborts the operation.
        in_valid = 1'b1;
        op_sub   = 1'b0;
        a        = 16'hABCD;
        b        = 16'h1357;
        c_in     = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_pass3_add_a", 32'(add_a), 32'hB);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_add", {27'd0, add_a, add_c0}, 32'd0);
        checkOutput("abort_add_b", 32'(add_b), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("abort_no_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 16'h1000, 16'h0001, 1'b0);
        checkOutput("post_abort_sum", 32'(gotSum), 32'h0FFF);
        checkOutput("post_abort_cout", 32'(gotCout), 32'd1);
        checkOutput("post_abort_latency", 32'(gotLat), 32'd4);
        finishOp();

        // Random operands against the reference model.
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            if (n % 8 == 0) rb = 16'h8000;
            refModel(rs, ra, rb, rc, hs, hc, ho);
            applyStimulus(rs, ra, rb, rc);
            checkOutput($sformatf("rnd%0d_sum", n), 32'(gotSum), 32'(hs));
            checkOutput($sformatf("rnd%0d_cout", n), 32'(gotCout), 32'(hc));
            checkOutput($sformatf("rnd%0d_ovf", n), 32'(gotOvf), 32'(ho));
            checkOutput($sformatf("rnd%0d_latency", n), 32'(gotLat), 32'd4);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            checkOutput($sformatf("rnd%0d_held_sum", n), 32'(sum), 32'(hs));
            finishOp();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
